// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - programmable modulo-M up/down counter with continuous/one-shot FSM
// Optional prescaler (and parameter PreWidth, port presc_i) built when MOD_COUNTER_PRESCALE_EN is defined.
module mod_counter #(
    parameter int Width = 8
`ifdef MOD_COUNTER_PRESCALE_EN
    ,
    parameter int PreWidth = 8
`endif
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                en_i,
    input  logic                up_i,
    input  logic                mode_i,
    input  logic                start_i,
    input  logic                clr_i,
    input  logic                load_i,
    input  logic [Width-1:0]    load_val_i,
    input  logic [Width-1:0]    mod_i,
`ifdef MOD_COUNTER_PRESCALE_EN
    input  logic [PreWidth-1:0] presc_i,
`endif
    output logic [Width-1:0]    q_o,
    output logic                tick_o,
    output logic                done_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [Width-1:0] q;
    logic [Width-1:0] q_next;
    logic             done;
    logic             done_next;

    logic [Width:0]   m_ext;
    logic [Width:0]   term_ext;
    logic [Width-1:0] start_val;
    logic [Width-1:0] term_val;
    logic [Width-1:0] load_clamped;
    logic             at_term;
    logic             en_eff;

    // Modulus arithmetic is one bit wider so mod_i==0 can stand for 2**Width.
    always_comb begin
        m_ext        = (mod_i == '0) ? {1'b1, {Width{1'b0}}} : {1'b0, mod_i};
        term_ext     = m_ext - 1'b1;
        start_val    = up_i ? '0 : term_ext[Width-1:0];
        term_val     = up_i ? term_ext[Width-1:0] : '0;
        load_clamped = ({1'b0, load_val_i} > term_ext) ? term_ext[Width-1:0] : load_val_i;
        // >= rather than == so a modulus lowered below q mid-run still wraps.
        at_term      = up_i ? ({1'b0, q} >= term_ext) : (q == '0);
    end

`ifdef MOD_COUNTER_PRESCALE_EN
    logic [PreWidth-1:0] pre_cnt;
    logic                pre_strobe;

    assign pre_strobe = (pre_cnt >= presc_i);
    assign en_eff     = en_i & pre_strobe;

    // Terminal wrap/stop always coincides with a strobe, which already returns the phase to 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_cnt <= '0;
        end else if (clr_i || (start_i && !load_i)) begin
            pre_cnt <= '0;
        end else if (state == RUN && en_i) begin
            if (pre_strobe) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + 1'b1;
            end
        end
    end
`else
    assign en_eff = en_i;
`endif

    always_comb begin
        state_next = state;
        q_next     = q;
        done_next  = done;
        if (clr_i) begin
            q_next     = '0;
            state_next = IDLE;
            done_next  = 1'b0;
        end else if (load_i) begin
            q_next = load_clamped;
        end else if (start_i) begin
            q_next     = start_val;
            state_next = RUN;
            done_next  = 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (en_eff) begin
                        if (at_term) begin
                            if (mode_i) begin
                                q_next     = term_val;
                                state_next = DONE;
                                done_next  = 1'b1;
                            end else begin
                                q_next = start_val;
                            end
                        end else if (up_i) begin
                            q_next = q + 1'b1;
                        end else begin
                            q_next = q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            q     <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            done  <= done_next;
        end
    end

    assign q_o    = q;
    assign done_o = done;
    assign busy_o = (state == RUN);
    assign tick_o = (state == RUN) && en_eff && at_term;

endmodule
